// File: rtl/draw_sched_pkg.sv
// Shared types and constants for the frame draw scheduler.
// Phase encoding doubles as the index into the per-source port vectors.
package draw_sched_pkg;

    typedef enum logic [1:0] {
        PH_CLEAR = 2'd0,
        PH_SNAKE = 2'd1,
        PH_ICON  = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } sched_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int NSRC     = 3;

    function automatic logic [NSRC-1:0] phase_onehot(input phase_e p);
        return {{(NSRC-1){1'b0}}, 1'b1} << p;
    endfunction

endpackage

// File: rtl/draw_scheduler_phase_watchdog.sv
// Per-phase cycle counter flagging when a phase has run MAX_CYCLES cycles.
// Only exists when SCHED_TIMEOUT_EN is defined, matching its single use site.
`ifdef SCHED_TIMEOUT_EN
module phase_watchdog #(
    parameter int MAX_CYCLES = 524288
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    logic [CW-1:0] count_r;

    // Phase cycle counter; saturates at the limit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (inc && !expired) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CW'(MAX_CYCLES - 1));

endmodule
`endif

// File: rtl/draw_scheduler.sv
// Frame sequencer and arbiter for the framebuffer write port: CLEAR, SNAKE, then ICON if dead.
// Define SCHED_TIMEOUT_EN to add a per-phase watchdog that forces a stuck phase to end.
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int X_W              = 10,
    parameter int Y_W              = 9,
    parameter int MAX_PHASE_CYCLES = 524288
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  dead,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*X_W-1:0]   src_x,
    input  logic [NSRC*Y_W-1:0]   src_y,
    input  logic [NSRC-1:0]       src_color,
    input  logic [NSRC-1:0]       src_done,
    output logic [NSRC-1:0]       src_start,
    output logic [NSRC-1:0]       src_ready,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic                  pixel_color,
    output logic                  pixel_we,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout_err
);

    sched_state_e    state_r, state_s;
    phase_e          phase_r, phase_s;
    logic            dead_l_r, dead_l_s;

    logic [NSRC-1:0] phase_oh_s;
    logic            in_run_s;
    logic            accept_s;
    logic            active_done_s;
    logic            wd_expired_s;
    logic            phase_end_s;
    logic [X_W-1:0]  sel_x_s;
    logic [Y_W-1:0]  sel_y_s;
    logic            sel_color_s;

    logic [NSRC-1:0] src_start_r, src_ready_r;
    logic [X_W-1:0]  x_r;
    logic [Y_W-1:0]  y_r;
    logic            pixel_color_r, pixel_we_r, busy_r, frame_done_r;
    logic            overrun_r, timeout_err_r;

    assign phase_oh_s    = phase_onehot(phase_r);
    assign in_run_s      = (state_r == S_RUN);
    assign accept_s      = in_run_s & (|(src_valid & phase_oh_s));
    assign active_done_s = |(src_done & phase_oh_s);
    assign sel_color_s   = |(src_color & phase_oh_s);
    assign phase_end_s   = in_run_s & (active_done_s | wd_expired_s);

`ifdef SCHED_TIMEOUT_EN
    phase_watchdog #(
        .MAX_CYCLES (MAX_PHASE_CYCLES)
    ) u_phase_watchdog (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (state_r == S_LAUNCH),
        .inc     (in_run_s),
        .expired (wd_expired_s)
    );
`else
    assign wd_expired_s = 1'b0;
`endif

    // Coordinate mux from the source that currently owns the port.
    always_comb begin
        sel_x_s = {X_W{1'b0}};
        sel_y_s = {Y_W{1'b0}};
        case (phase_r)
            PH_CLEAR: begin
                sel_x_s = src_x[0*X_W +: X_W];
                sel_y_s = src_y[0*Y_W +: Y_W];
            end
            PH_SNAKE: begin
                sel_x_s = src_x[1*X_W +: X_W];
                sel_y_s = src_y[1*Y_W +: Y_W];
            end
            PH_ICON: begin
                sel_x_s = src_x[2*X_W +: X_W];
                sel_y_s = src_y[2*Y_W +: Y_W];
            end
            default: begin
                sel_x_s = {X_W{1'b0}};
                sel_y_s = {Y_W{1'b0}};
            end
        endcase
    end

    // Next-state logic for the frame sequence.
    always_comb begin
        state_s  = state_r;
        phase_s  = phase_r;
        dead_l_s = dead_l_r;
        case (state_r)
            S_IDLE: begin
                if (frame_tick) begin
                    state_s  = S_LAUNCH;
                    phase_s  = PH_CLEAR;
                    dead_l_s = dead;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_s = S_RUN;
            end
            S_RUN: begin
                if (phase_end_s) begin
                    case (phase_r)
                        PH_CLEAR: begin
                            state_s = S_LAUNCH;
                            phase_s = PH_SNAKE;
                        end
                        PH_SNAKE: begin
                            if (dead_l_r) begin
                                state_s = S_LAUNCH;
                                phase_s = PH_ICON;
                            end else begin
                                state_s = S_FINISH;
                            end
                        end
                        default: begin
                            state_s = S_FINISH;
                        end
                    endcase
                end else begin
                    state_s = S_RUN;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            phase_r  <= PH_CLEAR;
            dead_l_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            phase_r  <= phase_s;
            dead_l_r <= dead_l_s;
        end
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_start_r  <= {NSRC{1'b0}};
            src_ready_r  <= {NSRC{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            src_start_r  <= (state_s == S_LAUNCH) ? phase_onehot(phase_s) : {NSRC{1'b0}};
            src_ready_r  <= (state_s == S_RUN) ? phase_onehot(phase_s) : {NSRC{1'b0}};
            busy_r       <= (state_s != S_IDLE);
            frame_done_r <= (state_s == S_FINISH);
            overrun_r    <= overrun_r | (frame_tick & busy_r);
        end
    end

    // Pixel write path: one-cycle latency, coordinates hold between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_r           <= {X_W{1'b0}};
            y_r           <= {Y_W{1'b0}};
            pixel_color_r <= 1'b0;
            pixel_we_r    <= 1'b0;
        end else if (accept_s) begin
            x_r           <= sel_x_s;
            y_r           <= sel_y_s;
            pixel_color_r <= sel_color_s;
            pixel_we_r    <= 1'b1;
        end else begin
            pixel_we_r    <= 1'b0;
        end
    end

    // Sticky watchdog error; a done in the expiring cycle wins over the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err_r <= 1'b0;
        end else begin
`ifdef SCHED_TIMEOUT_EN
            timeout_err_r <= timeout_err_r | (in_run_s & ~active_done_s & wd_expired_s);
`else
            timeout_err_r <= 1'b0;
`endif
        end
    end

    assign src_start   = src_start_r;
    assign src_ready   = src_ready_r;
    assign x           = x_r;
    assign y           = y_r;
    assign pixel_color = pixel_color_r;
    assign pixel_we    = pixel_we_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign overrun     = overrun_r;
    assign timeout_err = timeout_err_r;

endmodule
